// File: rtl/router_pkg.sv
// Shared types and header field layout for the router packet reader.
// A FIFO word is {header marker, byte}; header byte is {length[5:0], address[1:0]}.
package router_pkg;

   localparam int FIFO_W          = 9;
   localparam int DATA_W          = 8;
   localparam int HDR_BIT         = 8;
   localparam int LEN_MSB         = 7;
   localparam int LEN_LSB         = 2;
   localparam int LEN_W           = LEN_MSB - LEN_LSB + 1;
   localparam int ADDR_W          = 2;
   localparam int TIMEOUT_DEFAULT = 30;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_PARITY  = 2'd3
   } state_t;

   typedef struct packed {
      logic              perr;
      logic              eop;
      logic              sop;
      logic [DATA_W-1:0] data;
   } beat_t;

   function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr_byte);
      return hdr_byte[LEN_MSB:LEN_LSB];
   endfunction

endpackage

// File: rtl/router_out_skid.sv
// Two-entry output buffer. Handshake: a beat moves when out_valid && out_ready;
// the writer only pushes while count < 2; flush empties it in one cycle.
module router_out_skid
   import router_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       flush,
   input  logic       in_valid,
   input  beat_t      in_beat,
   output logic       out_valid,
   output beat_t      out_beat,
   input  logic       out_ready,
   output logic [1:0] count
);

   beat_t mem [2];
   logic  wr_ptr;
   logic  rd_ptr;
   logic  push;
   logic  pop;

   assign push      = in_valid && (count != 2'd2);
   assign pop       = out_valid && out_ready;
   assign out_valid = (count != 2'd0);
   assign out_beat  = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/router_pkt_reader.sv
// Pulls header/payload/parity words from router_fifo, checks parity and forwards
// beats through a 2-entry buffer; a stalled output beyond TIMEOUT flushes everything.
module router_pkt_reader
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [FIFO_W-1:0] fifo_data,
   output logic              fifo_read_enb,
   output logic              fifo_soft_reset,
   input  logic              dest_ready,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic              sop,
   output logic              eop,
   output logic              parity_err,
   output logic              pkt_done,
   output logic              frame_err,
   output state_t            state_dbg
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [LEN_W:0]   REQ_ONE = 1;
   localparam logic [LEN_W-1:0] LEN_ONE = 1;
   localparam logic [TW-1:0]    T_ONE   = 1;
   localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

   state_t            state;
   state_t            state_nxt;
   logic              rd_inflight;
   logic [LEN_W:0]    req_left;
   logic [LEN_W-1:0]  pay_cnt;
   logic [DATA_W-1:0] run_par;
   logic [TW-1:0]     tcnt;

   logic              buf_valid;
   beat_t             buf_beat;
   logic [1:0]        buf_cnt;
   logic              push_vld;
   beat_t             push_beat;

   logic              flush;
   logic              xfer;
   logic              word_vld;
   logic              word_hdr;
   logic [DATA_W-1:0] word_byte;
   logic [LEN_W-1:0]  word_len;
   logic [1:0]        occ;

   assign word_vld  = rd_inflight && !flush;
   assign word_hdr  = fifo_data[HDR_BIT];
   assign word_byte = fifo_data[DATA_W-1:0];
   assign word_len  = hdr_len(word_byte);
   assign xfer      = buf_valid && dest_ready;
   // A transfer in the same cycle always beats the timeout.
   assign flush     = buf_valid && !dest_ready && (tcnt == T_LAST);
   assign occ       = buf_cnt + {1'b0, rd_inflight};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (!fifo_empty) state_nxt = ST_HEADER;
            ST_HEADER:  if (word_vld && word_hdr)
                           state_nxt = (word_len == '0) ? ST_PARITY : ST_PAYLOAD;
            ST_PAYLOAD: if (word_vld && pay_cnt == LEN_ONE) state_nxt = ST_PARITY;
            ST_PARITY:  if (word_vld) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      fifo_read_enb = 1'b0;
      push_vld      = 1'b0;
      push_beat     = '0;
      frame_err     = 1'b0;
      // The header length is unknown until it returns, so HEADER keeps one read in flight.
      if (!fifo_empty && !flush && occ < 2'd2) begin
         case (state)
            ST_HEADER:             fifo_read_enb = !rd_inflight;
            ST_PAYLOAD, ST_PARITY: fifo_read_enb = (req_left != '0);
            default:               fifo_read_enb = 1'b0;
         endcase
      end
      if (word_vld) begin
         push_beat.data = word_byte;
         case (state)
            ST_HEADER: begin
               if (word_hdr) begin
                  push_vld      = 1'b1;
                  push_beat.sop = 1'b1;
               end else begin
                  frame_err = 1'b1;
               end
            end
            ST_PAYLOAD: push_vld = 1'b1;
            ST_PARITY: begin
               push_vld       = 1'b1;
               push_beat.eop  = 1'b1;
               push_beat.perr = (word_byte != run_par);
            end
            default: push_vld = 1'b0;
         endcase
      end
   end

   // req_left counts words still to request (payload plus parity) once the header is known.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_inflight <= 1'b0;
         req_left    <= '0;
         pay_cnt     <= '0;
         run_par     <= '0;
         tcnt        <= '0;
      end else if (flush) begin
         rd_inflight <= 1'b0;
         req_left    <= '0;
         pay_cnt     <= '0;
         run_par     <= '0;
         tcnt        <= '0;
      end else begin
         rd_inflight <= fifo_read_enb;
         if (xfer) begin
            tcnt <= '0;
         end else if (buf_valid) begin
            tcnt <= tcnt + T_ONE;
         end
         if (word_vld && state == ST_HEADER && word_hdr) begin
            req_left <= {1'b0, word_len} + REQ_ONE;
            pay_cnt  <= word_len;
            run_par  <= word_byte;
         end else begin
            if (fifo_read_enb && state != ST_HEADER) begin
               req_left <= req_left - REQ_ONE;
            end
            if (word_vld && state == ST_PAYLOAD) begin
               pay_cnt <= pay_cnt - LEN_ONE;
               run_par <= run_par ^ word_byte;
            end
         end
      end
   end

   router_out_skid u_skid (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (push_vld),
      .in_beat   (push_beat),
      .out_valid (buf_valid),
      .out_beat  (buf_beat),
      .out_ready (dest_ready),
      .count     (buf_cnt)
   );

   assign valid_out       = buf_valid;
   assign data_out        = buf_beat.data;
   assign sop             = buf_valid && buf_beat.sop;
   assign eop             = buf_valid && buf_beat.eop;
   assign parity_err      = buf_valid && buf_beat.eop && buf_beat.perr;
   assign pkt_done        = xfer && buf_beat.eop;
   assign fifo_soft_reset = flush;
   assign state_dbg       = state;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Bench for router_pkt_reader: FIFO model, packet-level expected-beat queue,
// output stall/timeout model, directed cases followed by randomized packets.
module tb_router_pkt_reader;
   import router_pkg::*;

   localparam int TB_TIMEOUT = 30;

   logic       clock;
   logic       reset;
   logic       fifo_empty;
   logic [8:0] fifo_data;
   logic       fifo_read_enb;
   logic       fifo_soft_reset;
   logic       dest_ready;
   logic       valid_out;
   logic [7:0] data_out;
   logic       sop;
   logic       eop;
   logic       parity_err;
   logic       pkt_done;
   logic       frame_err;
   state_t     state_dbg;

   logic [10:0] exp_q[$];
   logic [8:0]  fifo_q[$];
   logic        starve;
   logic        take_s;
   logic        sr_s;
   logic        prev_sr;
   logic        xfer;
   logic        exp_sr;
   logic [10:0] e;
   int          outstanding;
   int          stall_m;
   int          checks;
   int          errors;
   int          done_seen;
   int          fe_seen;
   int          sr_seen;
   int          exp_done;
   int          exp_fe;

   router_pkt_reader #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clock           (clock),
      .reset           (reset),
      .fifo_empty      (fifo_empty),
      .fifo_data       (fifo_data),
      .fifo_read_enb   (fifo_read_enb),
      .fifo_soft_reset (fifo_soft_reset),
      .dest_ready      (dest_ready),
      .valid_out       (valid_out),
      .data_out        (data_out),
      .sop             (sop),
      .eop             (eop),
      .parity_err      (parity_err),
      .pkt_done        (pkt_done),
      .frame_err       (frame_err),
      .state_dbg       (state_dbg)
   );

   // clock and watchdog
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // router_fifo model: one-cycle read latency, flushed by soft reset
   always @(posedge clock) begin
      if (reset) begin
         fifo_q.delete();
         fifo_empty <= 1'b1;
         fifo_data  <= '0;
      end else begin
         if (sr_s) begin
            fifo_q.delete();
         end else if (take_s) begin
            fifo_data <= fifo_q.pop_front();
         end
         fifo_empty <= (fifo_q.size() == 0) || starve;
      end
   end

   // scoreboard and stall/timeout model
   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         outstanding = 0;
         stall_m     = 0;
         prev_sr     = 1'b0;
         take_s      = 1'b0;
         sr_s        = 1'b0;
      end else begin
         take_s = fifo_read_enb && !fifo_empty;
         sr_s   = fifo_soft_reset;
         xfer   = valid_out && dest_ready;
         if (prev_sr) begin
            chk("flush_valid", valid_out, 0);
            chk("flush_state", state_dbg, ST_IDLE);
         end
         if (fifo_read_enb) begin
            chk("read_when_empty", fifo_empty, 0);
            chk("read_outstanding", (outstanding < 2), 1);
         end
         exp_sr = 1'b0;
         if (xfer) begin
            stall_m = 0;
         end else if (valid_out) begin
            stall_m++;
            if (stall_m == TB_TIMEOUT) begin
               exp_sr  = 1'b1;
               stall_m = 0;
            end
         end
         chk("soft_reset", fifo_soft_reset, exp_sr);
         if (xfer) begin
            chk("beat_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("beat", {parity_err, eop, sop, data_out}, e);
               chk("pkt_done", pkt_done, e[9]);
            end
         end else begin
            chk("pkt_done_idle", pkt_done, 0);
         end
         if (pkt_done) done_seen++;
         if (frame_err) fe_seen++;
         if (exp_sr) begin
            exp_q.delete();
            outstanding = 0;
            sr_seen++;
         end else begin
            outstanding = outstanding + int'(take_s) - int'(xfer) - int'(frame_err);
         end
         prev_sr = fifo_soft_reset;
      end
   end

   // driver tasks
   task automatic fifo_w(input logic [8:0] w);
      fifo_q.push_back(w);
   endtask

   task automatic exp_b(input logic perr, input logic eop_v, input logic sop_v, input logic [7:0] d);
      exp_q.push_back({perr, eop_v, sop_v, d});
   endtask

   task automatic push_pkt(input int len, input int strays, input bit bad);
      logic [7:0] h;
      logic [7:0] b;
      logic [7:0] par;
      repeat (strays) begin
         b = 8'($urandom);
         fifo_w({1'b0, b});
         exp_fe++;
      end
      h = {6'(len), 2'($urandom_range(0, 3))};
      fifo_w({1'b1, h});
      exp_b(1'b0, 1'b0, 1'b1, h);
      par = h;
      repeat (len) begin
         b = 8'($urandom);
         fifo_w({1'b0, b});
         exp_b(1'b0, 1'b0, 1'b0, b);
         par ^= b;
      end
      b = bad ? (par ^ (8'd1 << $urandom_range(0, 7))) : par;
      fifo_w({1'b0, b});
      exp_b(bad, 1'b1, 1'b0, b);
      exp_done++;
   endtask

   task automatic clear_counts();
      done_seen = 0;
      fe_seen   = 0;
      sr_seen   = 0;
      exp_done  = 0;
      exp_fe    = 0;
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_pkt_done"}, done_seen, exp_done);
      chk({tag, "_frame_err"}, fe_seen, exp_fe);
      chk({tag, "_state"}, state_dbg, ST_IDLE);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_read"}, fifo_read_enb, 0);
      chk({tag, "_soft_reset"}, fifo_soft_reset, 0);
      chk({tag, "_valid"}, valid_out, 0);
      chk({tag, "_data"}, data_out, 0);
      chk({tag, "_sop"}, sop, 0);
      chk({tag, "_eop"}, eop, 0);
      chk({tag, "_perr"}, parity_err, 0);
      chk({tag, "_pkt_done"}, pkt_done, 0);
      chk({tag, "_frame_err"}, frame_err, 0);
      chk({tag, "_state"}, state_dbg, ST_IDLE);
   endtask

   // mode 0: hold dest_ready, 1: toggle with starve bursts, 2: random ready and starve
   task automatic wait_drain(input string tag, input int budget, input int mode);
      int n;
      n = 0;
      while (n < budget && !(exp_q.size() == 0 && fifo_q.size() == 0 && outstanding == 0)) begin
         @(posedge clock);
         #1;
         case (mode)
            1: begin
               dest_ready = ~dest_ready;
               starve     = ((n % 7) < 2);
            end
            2: begin
               dest_ready = ($urandom_range(0, 3) != 0);
               starve     = ($urandom_range(0, 7) == 0);
            end
            default: ;
         endcase
         n++;
      end
      starve     = 1'b0;
      dest_ready = 1'b1;
      repeat (2) begin
         @(posedge clock);
         #1;
      end
      chk({tag, "_drain"}, (n < budget), 1);
   endtask

   initial begin
      int n;
      checks      = 0;
      errors      = 0;
      outstanding = 0;
      stall_m     = 0;
      starve      = 1'b0;
      dest_ready  = 1'b1;
      reset       = 1'b1;
      clear_counts();
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("idle_no_read", fifo_read_enb, 0);

      // good packet: header len 3, addr 1
      clear_counts();
      fifo_w(9'h10D); fifo_w(9'h011); fifo_w(9'h022); fifo_w(9'h033); fifo_w(9'h00D);
      exp_b(0, 0, 1, 8'h0D); exp_b(0, 0, 0, 8'h11); exp_b(0, 0, 0, 8'h22);
      exp_b(0, 0, 0, 8'h33); exp_b(0, 1, 0, 8'h0D);
      exp_done = 1;
      wait_drain("good_pkt", 200, 0);
      check_counts("good_pkt");

      // same packet with a wrong parity byte
      clear_counts();
      fifo_w(9'h10D); fifo_w(9'h011); fifo_w(9'h022); fifo_w(9'h033); fifo_w(9'h00E);
      exp_b(0, 0, 1, 8'h0D); exp_b(0, 0, 0, 8'h11); exp_b(0, 0, 0, 8'h22);
      exp_b(0, 0, 0, 8'h33); exp_b(1, 1, 0, 8'h0E);
      exp_done = 1;
      wait_drain("bad_parity", 200, 0);
      check_counts("bad_parity");

      // stray word before a zero-length header
      clear_counts();
      fifo_w(9'h055); fifo_w(9'h100); fifo_w(9'h000);
      exp_b(0, 0, 1, 8'h00); exp_b(0, 1, 0, 8'h00);
      exp_fe   = 1;
      exp_done = 1;
      wait_drain("stray", 200, 0);
      check_counts("stray");

      // output stalled until timeout flush
      clear_counts();
      dest_ready = 1'b0;
      fifo_w(9'h10D); fifo_w(9'h011); fifo_w(9'h022); fifo_w(9'h033); fifo_w(9'h00D);
      exp_b(0, 0, 1, 8'h0D); exp_b(0, 0, 0, 8'h11); exp_b(0, 0, 0, 8'h22);
      exp_b(0, 0, 0, 8'h33); exp_b(0, 1, 0, 8'h0D);
      n = 0;
      while (n < 200 && sr_seen == 0) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("timeout_seen", sr_seen, 1);
      chk("timeout_valid_next", valid_out, 0);
      chk("timeout_state_next", state_dbg, ST_IDLE);
      dest_ready = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      chk("timeout_no_pkt_done", done_seen, 0);
      chk("timeout_fifo_flushed", fifo_q.size(), 0);
      chk("timeout_quiet", valid_out, 0);

      // reset in the middle of a packet
      clear_counts();
      push_pkt(12, 0, 0);
      repeat (6) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check_all_zero("reset_mid");
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      clear_counts();
      repeat (5) begin
         @(posedge clock);
         #1;
         chk("reset_mid_no_read", fifo_read_enb, 0);
      end
      chk("reset_mid_no_pkt_done", done_seen, 0);

      // 20-byte payload with dest_ready toggling and empty bursts
      clear_counts();
      push_pkt(20, 0, 0);
      wait_drain("toggle", 1000, 1);
      check_counts("toggle");

      // randomized packets back to back, including length boundaries
      clear_counts();
      for (int p = 0; p < 10; p++) begin
         push_pkt((p == 0) ? 0 : (p == 1) ? 63 : $urandom_range(0, 63),
                  $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
      end
      wait_drain("random", 6000, 2);
      check_counts("random");
      chk("random_no_timeout", sr_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/router_pkt_reader.md
ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

Interface
REQ-001 clock  input  1  single clock; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 fifo_empty  input  1  router_fifo empty flag.
REQ-004 fifo_data  input  9  router_fifo data_out; bit 8 = header marker (lfd), [7:0] = byte.
REQ-005 fifo_read_enb  output  1  read strobe to router_fifo.
REQ-006 fifo_soft_reset  output  1  one-cycle flush pulse to router_fifo on timeout.
REQ-007 dest_ready  input  1  downstream accepts beat.
REQ-008 valid_out  output  1  data_out holds a beat.
REQ-009 data_out  output  8  forwarded byte.
REQ-010 sop, eop  output  1 each  header beat / parity beat markers, qualified by valid_out.
REQ-011 parity_err  output  1  qualified by valid_out & eop; computed parity mismatch.
REQ-012 pkt_done, frame_err  output  1 each  one-cycle status pulses.
REQ-013 TIMEOUT parameter, default 30, cycles of stalled output before flush.

Function
REQ-020 FIFO read latency: fifo_data valid the cycle after fifo_read_enb=1 with fifo_empty=0.
REQ-021 fifo_read_enb SHALL assert only when fifo_empty=0, FSM not IDLE-flushing, and (buffered beats + reads in flight) < 2.
REQ-022 Output path SHALL be a 2-entry buffer; beat transfers when valid_out & dest_ready; no loss, no duplication.
REQ-023 States: IDLE, HEADER, PAYLOAD, PARITY.
REQ-024 IDLE -> HEADER when fifo_empty=0; word returned with bit8=0 in HEADER SHALL be discarded, frame_err pulsed, state stays HEADER.
REQ-025 HEADER word (bit8=1): length = byte[7:2], address = byte[1:0]; forwarded with sop=1; running parity := byte; -> PAYLOAD if length>0, else PARITY.
REQ-026 PAYLOAD: each word forwarded, parity ^= byte, 6-bit down-counter decrements; at zero -> PARITY.
REQ-027 PARITY: word forwarded with eop=1, parity_err = (byte != running parity); -> IDLE; pkt_done pulses when the eop beat transfers.
REQ-028 Reads SHALL stop after the parity word is requested; no read of the next packet issued before FSM re-enters HEADER.
REQ-029 Timeout: counter increments each cycle valid_out=1 & dest_ready=0, clears on any transfer; reaching TIMEOUT SHALL pulse fifo_soft_reset one cycle.
REQ-030 On timeout: output buffer and in-flight read discarded, counters cleared, FSM -> IDLE next cycle; valid_out=0 next cycle.
REQ-031 Simultaneous timeout and transfer: transfer wins, counter clears, no flush.
REQ-032 fifo_empty rising mid-packet: reads pause, state held, no timeout (timeout counts output stall only).

Reset
REQ-040 reset SHALL force: state IDLE, fifo_read_enb=0, fifo_soft_reset=0, valid_out=0, data_out=0, sop=eop=parity_err=pkt_done=frame_err=0, all counters and parity 0, buffer empty.
REQ-041 Reset mid-packet SHALL abandon the packet; no pkt_done issued.

Structure
REQ-050 router_pkg SHALL hold: state enum, header field positions (LEN_MSB=7, LEN_LSB=2, ADDR width 2), data widths 9/8, default TIMEOUT.
REQ-051 One sub-module router_out_skid (2-entry valid/ready buffer with flush input) SHALL implement REQ-022.

Verification
REQ-060 Assert reset mid-run -> all outputs 0 same cycle, IDLE; release -> no read until fifo_empty=0.
REQ-061 Load 9'h10D,0x11,0x22,0x33,0x0D, dest_ready=1 -> 5 beats 0D,11,22,33,0D; sop on first, eop on last, parity_err=0, one pkt_done.
REQ-062 Same packet with parity 0x0E -> eop beat parity_err=1, pkt_done still pulses.
REQ-063 Header beat presented, dest_ready=0 for 30 cycles -> fifo_soft_reset pulse on cycle 30, valid_out=0 next cycle, state IDLE.
REQ-064 dest_ready toggling 1/0 over 20-byte payload -> exact byte order, fifo_read_enb never with 2 beats outstanding, no read when fifo_empty=1.
REQ-065 Stray 9'h055 before header 9'h100, parity 0x00 -> frame_err pulse, then 2 beats (00 sop, 00 eop), parity_err=0.
